// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one registered signed add/sub/select datapath among NUM_REQ
//   requesters. A round-robin arbiter grants one request at a time. The
//   request runs through a single registered ALU stage. The result returns
//   on one response channel, tagged with the requester ID.
//
//   Optional build macro: ALU_SAT_EN
//     defined   - result clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1],
//                 then sign-extended to DATA_W+1 bits
//     undefined - exact DATA_W+1 result
//
//   Handshake semantics (both channels): a transfer happens on a rising
//   clk edge where valid and ready are both high. Requesters hold valid and
//   payload stable until ready. The response holds valid, data and id
//   stable until rsp_ready.
//
//   FSM state is held in r_state (enum state_t). Checkers can bind to it.
//   The busy output is its IDLE / not-IDLE decode.
module alu_share_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  input  logic [NUM_REQ*2-1:0]        req_op,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic signed [DATA_W:0]      rsp_data,
  output logic [ID_W-1:0]             rsp_id,
  output logic                        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_A   = 2'b00;
  localparam logic [1:0] OP_B   = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

`ifdef ALU_SAT_EN
  localparam logic signed [DATA_W:0] SAT_MAX = {2'b00, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W:0] SAT_MIN = {2'b11, {(DATA_W-1){1'b0}}};
`endif

  state_t                    r_state;
  logic [ID_W-1:0]           r_last_grant;
  logic signed [DATA_W-1:0]  r_a;
  logic signed [DATA_W-1:0]  r_b;
  logic [1:0]                r_op;
  logic [ID_W-1:0]           r_id;
  logic                      r_rsp_valid;
  logic signed [DATA_W:0]    r_rsp_data;
  logic [ID_W-1:0]           r_rsp_id;

  logic                      w_gnt_vld;
  logic [ID_W-1:0]           w_gnt_idx;
  logic [NUM_REQ-1:0]        w_gnt_onehot;
  logic signed [DATA_W:0]    w_sa;
  logic signed [DATA_W:0]    w_sb;
  logic signed [DATA_W:0]    w_raw;
  logic signed [DATA_W:0]    w_res;

  // Round-robin pick: first valid requester after last_grant, wrapping modulo NUM_REQ
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int unsigned     cand_i;
      logic [ID_W-1:0] cand;
      cand_i = (int'(r_last_grant) + k) % NUM_REQ;
      cand   = ID_W'(cand_i);
      if (!w_gnt_vld && req_valid[cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = cand;
      end
    end
    w_gnt_onehot = NUM_REQ'(1) << w_gnt_idx;
  end

  // Ready is asserted only in IDLE and only toward the winner. It is also
  // held low while reset is asserted, so no accept can be seen during reset.
  assign req_ready = (rst_n && (r_state == S_IDLE) && w_gnt_vld) ? w_gnt_onehot : '0;

  // ALU on the captured operands: sign-extend, select/add/sub, optional clamp
  always_comb begin
    w_sa = {r_a[DATA_W-1], r_a};
    w_sb = {r_b[DATA_W-1], r_b};
    case (r_op)
      OP_A:    w_raw = w_sa;
      OP_B:    w_raw = w_sb;
      OP_ADD:  w_raw = w_sa + w_sb;
      default: w_raw = w_sa - w_sb;
    endcase
`ifdef ALU_SAT_EN
    if (w_raw > SAT_MAX)      w_res = SAT_MAX;
    else if (w_raw < SAT_MIN) w_res = SAT_MIN;
    else                      w_res = w_raw;
`else
    w_res = w_raw;
`endif
  end

  // Control FSM: IDLE grants and captures, EXEC registers the result, RESP waits for the consumer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= '0;
      r_id         <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_id     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_a          <= req_a[w_gnt_idx*DATA_W +: DATA_W];
            r_b          <= req_b[w_gnt_idx*DATA_W +: DATA_W];
            r_op         <= req_op[w_gnt_idx*2 +: 2];
            r_id         <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data  <= w_res;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter (NUM_REQ=4, DATA_W=8).
//   Expected values are hand-computed. Alternatives are selected with
//   ALU_SAT_EN to match the build.
module tb_alu_share_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic [NR*2-1:0]   req_op;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DW:0]       rsp_data;
  logic [1:0]        rsp_id;
  logic              busy;

  int n_vec;
  int n_err;

  logic [DW:0] exp_d [NR];

  alu_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  // Clock: 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [1:0] op);
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
    req_op[idx*2 +: 2]  = op;
  endtask

  // One request from a single requester, rsp_ready held high; starts in IDLE
  task automatic run_single(input int idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [1:0] op, input logic [DW:0] exp, input string tag);
    set_req(idx, a, b, op);
    req_valid      = '0;
    req_valid[idx] = 1'b1;
    rsp_ready      = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(4'b0001 << idx));
    tick();
    req_valid = '0;
    #1;
    check({tag, "_exec_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_exec_busy"}, 32'(busy), 32'd1);
    check({tag, "_exec_rspv"}, 32'(rsp_valid), 32'd0);
    tick();
    check({tag, "_rspv"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, 32'(rsp_data), 32'(exp));
    check({tag, "_id"}, 32'(rsp_id), 32'(idx));
    tick();
    check({tag, "_done_rspv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_hold_data"}, 32'(rsp_data), 32'(exp));
    check({tag, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;

    // Test 1: reset with random inputs, then idle with no valids
    req_valid = NR'($urandom_range(1, 15));
    req_a     = $urandom();
    req_b     = $urandom();
    req_op    = NR*2'($urandom_range(0, 255));
    rsp_ready = 1'($urandom_range(0, 1));
    tick();
    tick();
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rspv", 32'(rsp_valid), 32'd0);
    check("idle_ready", 32'(req_ready), 32'd0);

    // Test 2: requester 2, 100 + 50
`ifdef ALU_SAT_EN
    run_single(2, 8'd100, 8'd50, 2'b10, 9'h07F, "r2_add");
`else
    run_single(2, 8'd100, 8'd50, 2'b10, 9'h096, "r2_add");
`endif

    // Test 3: requester 0, -128 - 127, select a, select b
`ifdef ALU_SAT_EN
    run_single(0, 8'h80, 8'h7F, 2'b11, 9'h180, "r0_sub");
`else
    run_single(0, 8'h80, 8'h7F, 2'b11, 9'h101, "r0_sub");
`endif
    run_single(0, 8'hFB, 8'h00, 2'b00, 9'h1FB, "r0_sela");
    run_single(0, 8'h00, 8'h07, 2'b01, 9'h007, "r0_selb");

    // Test 4: fresh reset, all four valid, round-robin 0,1,2,3,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    set_req(0, 8'd10, 8'd3, 2'b10);     // 13
    set_req(1, 8'hEC, 8'd5, 2'b11);     // -20 - 5 = -25
    set_req(2, 8'd7, 8'hF7, 2'b01);     // b = -9
    set_req(3, 8'd60, 8'd70, 2'b10);    // 130
    exp_d[0] = 9'h00D;
    exp_d[1] = 9'h1E7;
    exp_d[2] = 9'h1F7;
`ifdef ALU_SAT_EN
    exp_d[3] = 9'h07F;
`else
    exp_d[3] = 9'h082;
`endif
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 6; n++) begin
      int g;
      g = n % NR;
      check($sformatf("rr%0d_ready", n), 32'(req_ready), 32'(4'b0001 << g));
      tick();
      check($sformatf("rr%0d_exec_ready", n), 32'(req_ready), 32'd0);
      tick();
      check($sformatf("rr%0d_resp_ready", n), 32'(req_ready), 32'd0);
      check($sformatf("rr%0d_rspv", n), 32'(rsp_valid), 32'd1);
      check($sformatf("rr%0d_id", n), 32'(rsp_id), 32'(g));
      check($sformatf("rr%0d_data", n), 32'(rsp_data), 32'(exp_d[g]));
      tick();
    end

    // Test 5: backpressure on requester 2 (last grant was 1)
    rsp_ready = 1'b0;
    check("bp_ready", 32'(req_ready), 32'b0100);
    tick();
    tick();
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_rspv", c), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d_data", c), 32'(rsp_data), 32'(exp_d[2]));
      check($sformatf("bp%0d_id", c), 32'(rsp_id), 32'd2);
      check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_rel_rspv", 32'(rsp_valid), 32'd0);
    check("bp_next_ready", 32'(req_ready), 32'b1000);

    // Test 6: reset while requester 3 is in EXEC
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rspv", 32'(rsp_valid), 32'd0);
    check("mid_data", 32'(rsp_data), 32'd0);
    check("mid_id", 32'(rsp_id), 32'd0);
    check("mid_busy0", 32'(busy), 32'd0);
    check("mid_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    check("mid_hold_rspv", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_ready", 32'(req_ready), 32'b0001);
    tick();
    check("post_exec_rspv", 32'(rsp_valid), 32'd0);
    tick();
    check("post_rspv", 32'(rsp_valid), 32'd1);
    check("post_id", 32'(rsp_id), 32'd0);
    check("post_data", 32'(rsp_data), 32'(exp_d[0]));
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
